// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial carry-lookahead adder.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   GROUP_W    : bits handled per clock (one lookahead group)
//   cnt_width(): group-counter width, never less than one bit
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // $clog2(1) is 0, so a single-group adder still needs a 1-bit counter.
    function automatic int cnt_width(input int groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// ---------------------------------------------------------------------------
// cla_lookahead4
// Purely combinational 4-bit carry-lookahead unit. Every carry is a flat
// sum-of-products of G, P and c0, so no carry ripples through the group.
//   i_g[3:0]  : bit generates
//   i_p[3:0]  : bit propagates
//   i_c0      : carry into the group
//   o_c[4:1]  : carries into bits 1..3 and out of the group (C4)
//   o_gg      : group generate  (group produces a carry by itself)
//   o_pg      : group propagate (group passes c0 straight through)
// ---------------------------------------------------------------------------
module cla_lookahead4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] i_g,
    input  logic [GROUP_W-1:0] i_p,
    input  logic               i_c0,
    output logic [GROUP_W:1]   o_c,
    output logic               o_gg,
    output logic               o_pg
);

    assign o_c[1] = i_g[0]
                  | (i_p[0] & i_c0);

    assign o_c[2] = i_g[1]
                  | (i_p[1] & i_g[0])
                  | (i_p[1] & i_p[0] & i_c0);

    assign o_c[3] = i_g[2]
                  | (i_p[2] & i_g[1])
                  | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c0);

    assign o_c[4] = i_g[3]
                  | (i_p[3] & i_g[2])
                  | (i_p[3] & i_p[2] & i_g[1])
                  | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
                  | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_c0);

    assign o_gg = i_g[3]
                | (i_p[3] & i_g[2])
                | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

    assign o_pg = &i_p;

endmodule

// File: rtl/gp_full_adder.sv
// ---------------------------------------------------------------------------
// GPFullAdder
// Single-bit adder cell that exports generate/propagate for a lookahead unit
// instead of producing its own carry-out.
//   i_a, i_b : operand bits
//   i_c      : carry into this bit (from the lookahead unit)
//   o_g      : generate  = a & b
//   o_p      : propagate = a ^ b
//   o_s      : sum bit   = p ^ c
// ---------------------------------------------------------------------------
module GPFullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_g,
    output logic o_p,
    output logic o_s
);

    assign o_g = i_a & i_b;
    assign o_p = i_a ^ i_b;
    assign o_s = o_p ^ i_c;

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_adder
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead group per clock, least
// significant group first. The group carry-out is registered and becomes the
// carry-in of the next group.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b, cin  : operands and carry-in, captured when start is accepted
//   busy       : high while groups are being processed
//   done       : one-cycle pulse when sum/cout/ovf are valid
//   sum        : result register (partial while busy)
//   cout       : carry out of the MSB
//   ovf        : signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module cla_nibble_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int GROUPS = WIDTH / GROUP_W;
    localparam int CNT_W  = cnt_width(GROUPS);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    // ------------------------------------------------------------------
    // Current-group slice and lookahead signals
    // ------------------------------------------------------------------
    logic [CNT_W+1:0]   w_base;       // bit offset of the current group
    logic [GROUP_W-1:0] w_a_grp;
    logic [GROUP_W-1:0] w_b_grp;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_s;
    logic [GROUP_W-1:0] w_cbit;       // carry into each bit cell
    logic [GROUP_W:1]   w_c;
    logic               w_gg;
    logic               w_pg;
    logic               w_carry_next;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    // Group width is fixed at four, so the offset is the counter shifted by 2.
    assign w_base  = {r_cnt, 2'b00};
    assign w_a_grp = r_a[w_base +: GROUP_W];
    assign w_b_grp = r_b[w_base +: GROUP_W];
    assign w_last  = (r_cnt == CNT_W'(GROUPS - 1));

    // Bit 0 takes the registered carry; bits 1..3 take lookahead carries.
    assign w_cbit  = {w_c[3:1], r_carry};

    for (genvar i = 0; i < GROUP_W; i++) begin : g_bit
        GPFullAdder u_cell (
            .i_a (w_a_grp[i]),
            .i_b (w_b_grp[i]),
            .i_c (w_cbit[i]),
            .o_g (w_g[i]),
            .o_p (w_p[i]),
            .o_s (w_s[i])
        );
    end

    cla_lookahead4 u_lookahead (
        .i_g  (w_g),
        .i_p  (w_p),
        .i_c0 (r_carry),
        .o_c  (w_c),
        .o_gg (w_gg),
        .o_pg (w_pg)
    );

    // Carry forwarded to the next group, formed from the group G/P pair.
    // Logically identical to C4; it is the hook a second lookahead level
    // would use.
    assign w_carry_next = w_gg | (w_pg & r_carry);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // start is deliberately ignored here, so back-to-back
                // requests always pass through one IDLE cycle.
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                BUSY: begin
                    r_sum[w_base +: GROUP_W] <= w_s;
                    r_carry                  <= w_carry_next;
                    if (w_last) begin
                        // C3 is the carry into the MSB, C4 the carry out.
                        r_cout <= w_c[4];
                        r_ovf  <= w_c[3] ^ w_c[4];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
module tb_cla_nibble_serial_adder;

    localparam int WIDTH  = 16;
    localparam int GROUPS = WIDTH / 4;
    localparam int LAT    = GROUPS + 1;   // negedges from acceptance to done

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition; result is {sum, cout, ovf}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             c);
        logic [WIDTH:0] t;
        logic           v;
        t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return {t[WIDTH-1:0], t[WIDTH], v};
    endfunction

    // Issues one add and waits for done. lat = negedges from acceptance to
    // done (-1 on timeout), nbusy = negedges on which busy was seen.
    task automatic run_add(input  logic [WIDTH-1:0] ta,
                           input  logic [WIDTH-1:0] tb,
                           input  logic             tc,
                           output logic [WIDTH+1:0] res,
                           output int               lat,
                           output int               nbusy);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        res = {sum, cout, ovf};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        total++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b sum=%h, want all 0",
                     busy, done, sum);
        end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] va [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hA5A5};
        logic [WIDTH-1:0] vb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 16'h5A5A};
        logic             vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH+1:0] res, exp;
        int lat, nbusy;
        for (int i = 0; i < 6; i++) begin
            run_add(va[i], vb[i], vc[i], res, lat, nbusy);
            exp = model(va[i], vb[i], vc[i]);
            total++;
            if (res !== exp) begin
                bad++;
                $display("FAIL directed_%0d: %h+%h+%b got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, va[i], vb[i], vc[i], res[WIDTH+1:2], res[1], res[0],
                         exp[WIDTH+1:2], exp[1], exp[0]);
            end
            total++;
            if (lat !== LAT || nbusy !== GROUPS) begin
                bad++;
                $display("FAIL directed_timing_%0d: got done at %0d busy cycles %0d, want %0d and %0d",
                         i, lat, nbusy, LAT, GROUPS);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || {sum, cout, ovf} !== exp) begin
                bad++;
                $display("FAIL directed_hold_%0d: got done=%b busy=%b sum=%h, want 0 0 %h",
                         i, done, busy, sum, exp[WIDTH+1:2]);
            end
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] ta, tb;
        logic             tc;
        logic [WIDTH+1:0] res, exp;
        int lat, nbusy;
        for (int i = 0; i < 40; i++) begin
            ta = WIDTH'($urandom);
            tb = WIDTH'($urandom);
            tc = 1'($urandom);
            run_add(ta, tb, tc, res, lat, nbusy);
            exp = model(ta, tb, tc);
            total++;
            if (res !== exp || lat !== LAT) begin
                bad++;
                $display("FAIL random_%0d: %h+%h+%b got {sum,cout,ovf}=%h lat=%0d, want %h lat=%0d",
                         i, ta, tb, tc, res, lat, exp, LAT);
            end
        end
    endtask

    // start held high: DONE ignores it and the next acceptance happens on
    // the following IDLE cycle, so done pulses are GROUPS+2 cycles apart.
    task automatic test_back_to_back;
        int pulses = 0;
        int first  = -1;
        int second = -1;
        int third  = -1;
        logic [WIDTH+1:0] exp;
        exp = model(16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; cin = 1'b1; start = 1'b1;
        for (int i = 1; i <= 3 * (GROUPS + 2); i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                else if (third < 0) third = i;
                total++;
                if ({sum, cout, ovf} !== exp) begin
                    bad++;
                    $display("FAIL b2b_result: got sum=%h, want %h", sum, exp[WIDTH+1:2]);
                end
            end
        end
        start = 1'b0;
        total++;
        if (pulses !== 3 || second - first !== GROUPS + 2 || third - second !== GROUPS + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got pulses=%0d at %0d,%0d,%0d, want 3 spaced %0d",
                     pulses, first, second, third, GROUPS + 2);
        end
        // Let any in-flight add finish before the next scenario.
        for (int i = 0; i < 2 * (GROUPS + 2) && (busy || done); i++) @(negedge clk);
    endtask

    task automatic test_operand_change;
        logic [WIDTH+1:0] exp;
        int lat = -1;
        exp = model(16'h00FF, 16'h0F0F, 1'b0);
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            // Scramble inputs and re-request while busy.
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            start = 1'($urandom);
        end
        start = 1'b0;
        total++;
        if (sum !== 16'h100E || {sum, cout, ovf} !== exp || lat !== LAT) begin
            bad++;
            $display("FAIL operand_change: got sum=%h cout=%b lat=%0d, want sum=100E cout=0 lat=%0d",
                     sum, cout, lat, LAT);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL no_restart: got busy=%b done=%b after done, want 0 0", busy, done);
        end
    endtask

    task automatic test_midop_reset;
        logic [WIDTH+1:0] res, exp;
        int lat, nbusy;
        int seen = 0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            bad++;
            $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * GROUPS + 2; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d cycles with busy/done after reset, want 0", seen);
        end
        run_add(16'h0001, 16'h0002, 1'b0, res, lat, nbusy);
        exp = model(16'h0001, 16'h0002, 1'b0);
        total++;
        if (res !== exp || res[WIDTH+1:2] !== 16'h0003 || lat !== LAT) begin
            bad++;
            $display("FAIL after_reset_add: got sum=%h lat=%0d, want 0003 lat=%0d",
                     res[WIDTH+1:2], lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_operand_change();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound in case the design never signals done.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
